// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control slice:
// branch types, ALU ops, operand selects and the branch FSM states.
package mips_ctrl_pkg;

   typedef enum logic [1:0] {
      BR_BEQ = 2'b00,
      BR_BNE = 2'b01,
      BR_BGT = 2'b10,
      BR_BLE = 2'b11
   } br_type_e;

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_TARGET  = 2'b01,
      S_COMPARE = 2'b10,
      S_RESOLVE = 2'b11
   } br_state_e;

   localparam logic [2:0] ALU_NOP = 3'b000;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;

   localparam logic [1:0] SRC_A_PC  = 2'b00;
   localparam logic [1:0] SRC_A_RS  = 2'b01;
   localparam logic [1:0] SRC_B_RT  = 2'b00;
   localparam logic [1:0] SRC_B_OFF = 2'b11;

   function automatic logic br_cond(
      input logic [1:0] t,
      input logic       z,
      input logic       g
   );
      logic r;
      r = 1'b0;
      case (t)
         BR_BEQ:  r = z;
         BR_BNE:  r = ~z;
         BR_BGT:  r = g;
         BR_BLE:  r = ~g;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins
// over increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/branch_seq_ctrl.sv
// Branch sequencer: computes the target, compares rs/rt, then
// resolves the condition and enables the PC on a taken branch.
module branch_seq_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       branch_type,
   input  logic             alu_zero,
   input  logic             alu_gt,
   input  logic             clr_stats,
   output logic             busy,
   output logic             done,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_op,
   output logic             aluout_write,
   output logic [1:0]       branch_op,
   output logic             pc_write,
   output logic             taken,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] taken_cnt
);

   br_state_e  state_q, state_d;
   logic [1:0] type_q, type_d;
   logic [1:0] flag_q, flag_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         type_q  <= 2'b00;
         flag_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         type_q  <= type_d;
         flag_q  <= flag_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      type_d       = type_q;
      flag_d       = flag_q;
      alu_src_a    = 2'b00;
      alu_src_b    = 2'b00;
      alu_op       = ALU_NOP;
      aluout_write = 1'b0;
      branch_op    = 2'b00;
      taken        = 1'b0;
      pc_write     = 1'b0;
      done         = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               type_d  = branch_type;
               state_d = S_TARGET;
            end
         end
         S_TARGET: begin
            alu_src_a    = SRC_A_PC;
            alu_src_b    = SRC_B_OFF;
            alu_op       = ALU_ADD;
            aluout_write = 1'b1;
            state_d      = S_COMPARE;
         end
         S_COMPARE: begin
            alu_src_a = SRC_A_RS;
            alu_src_b = SRC_B_RT;
            alu_op    = ALU_SUB;
            flag_d    = {alu_zero, alu_gt};
            state_d   = S_RESOLVE;
         end
         S_RESOLVE: begin
            // PC takes ALUOut, so only the enable is needed here
            branch_op = type_q;
            taken     = br_cond(type_q, flag_q[1], flag_q[0]);
            pc_write  = taken;
            done      = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy = (state_q != S_IDLE);

   sat_counter #(.W(CNT_W)) u_branch_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (done),
      .clr     (clr_stats),
      .cnt     (branch_cnt)
   );

   sat_counter #(.W(CNT_W)) u_taken_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (taken),
      .clr     (clr_stats),
      .cnt     (taken_cnt)
   );

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Bench for branch_seq_ctrl: directed scenarios plus random traffic,
// all checked every cycle against a phase-count model.
module tb_branch_seq_ctrl;
   import mips_ctrl_pkg::*;

   logic clk, reset_n, start, alu_zero, alu_gt, clr_stats;
   logic [1:0] branch_type;

   logic        busy, done, aluout_write, pc_write, taken;
   logic [1:0]  alu_src_a, alu_src_b, branch_op;
   logic [2:0]  alu_op;
   logic [15:0] branch_cnt, taken_cnt;

   logic        busy2, done2, aluout_write2, pc_write2, taken2;
   logic [1:0]  alu_src_a2, alu_src_b2, branch_op2;
   logic [2:0]  alu_op2;
   logic [1:0]  branch_cnt2, taken_cnt2;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   branch_seq_ctrl dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .branch_type(branch_type), .alu_zero(alu_zero),
      .alu_gt(alu_gt), .clr_stats(clr_stats),
      .busy(busy), .done(done), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op),
      .aluout_write(aluout_write), .branch_op(branch_op),
      .pc_write(pc_write), .taken(taken),
      .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
   );

   branch_seq_ctrl #(.CNT_W(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .start(start),
      .branch_type(branch_type), .alu_zero(alu_zero),
      .alu_gt(alu_gt), .clr_stats(clr_stats),
      .busy(busy2), .done(done2), .alu_src_a(alu_src_a2),
      .alu_src_b(alu_src_b2), .alu_op(alu_op2),
      .aluout_write(aluout_write2), .branch_op(branch_op2),
      .pc_write(pc_write2), .taken(taken2),
      .branch_cnt(branch_cnt2), .taken_cnt(taken_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  nm, act, exp, $time);
      end
   endtask

   // model: cycles elapsed since start (0 = idle), latched type/flags
   int         m_ph = 0;
   logic [1:0] m_ty = 0;
   logic       m_z = 0, m_g = 0;
   int         m_bc = 0, m_tc = 0, m_bc2 = 0, m_tc2 = 0;

   function automatic int sat(input int v, input int mx);
      return (v >= mx) ? mx : v + 1;
   endfunction

   always @(negedge clk) begin
      logic e_tk;
      if (!reset_n) begin
         m_ph = 0; m_ty = 0; m_z = 0; m_g = 0;
         m_bc = 0; m_tc = 0; m_bc2 = 0; m_tc2 = 0;
      end
      case (m_ty)
         2'd0: e_tk = m_z;
         2'd1: e_tk = !m_z;
         2'd2: e_tk = m_g;
         default: e_tk = !m_g;
      endcase
      if (m_ph != 3) e_tk = 1'b0;
      chk("busy", busy, m_ph != 0);
      chk("done", done, m_ph == 3);
      chk("taken", taken, e_tk);
      chk("pc_write", pc_write, e_tk);
      chk("branch_op", branch_op, (m_ph == 3) ? m_ty : 2'd0);
      chk("aluout_write", aluout_write, m_ph == 1);
      chk("alu_src_a", alu_src_a, (m_ph == 2) ? 2'd1 : 2'd0);
      chk("alu_src_b", alu_src_b, (m_ph == 1) ? 2'd3 : 2'd0);
      chk("alu_op", alu_op,
          (m_ph == 1) ? ALU_ADD : (m_ph == 2) ? ALU_SUB : 3'd0);
      chk("branch_cnt", branch_cnt, m_bc);
      chk("taken_cnt", taken_cnt, m_tc);
      chk("busy2", busy2, m_ph != 0);
      chk("branch_cnt2", branch_cnt2, m_bc2);
      chk("taken_cnt2", taken_cnt2, m_tc2);
      if (reset_n) begin
         if (clr_stats) begin
            m_bc = 0; m_tc = 0; m_bc2 = 0; m_tc2 = 0;
         end else if (m_ph == 3) begin
            m_bc  = sat(m_bc, 65535);
            m_bc2 = sat(m_bc2, 3);
            if (e_tk) begin
               m_tc  = sat(m_tc, 65535);
               m_tc2 = sat(m_tc2, 3);
            end
         end
         if (m_ph == 2) begin
            m_z = alu_zero; m_g = alu_gt;
         end
         if (m_ph == 0) begin
            if (start) begin
               m_ty = branch_type; m_ph = 1;
            end
         end else begin
            m_ph = (m_ph + 1) % 4;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_br(input logic [1:0] t, input logic z,
                         input logic g);
      start = 1; branch_type = t;
      step();
      start = 0;
      step();
      alu_zero = z; alu_gt = g;
      step();
      alu_zero = 0; alu_gt = 0;
      step();
   endtask

   int t1, t2;

   initial begin
      reset_n = 0; start = 0; branch_type = 0;
      alu_zero = 0; alu_gt = 0; clr_stats = 0;
      step();
      step();
      chk("rst_busy", busy, 0);
      chk("rst_branch_cnt", branch_cnt, 0);
      chk("rst_taken_cnt", taken_cnt, 0);
      reset_n = 1;
      step();

      // beq, zero=1 -> taken
      start = 1; branch_type = 2'b00;
      step();
      start = 0;
      chk("beq_busy", busy, 1);
      step();
      alu_zero = 1;
      step();
      alu_zero = 0;
      chk("beq_done", done, 1);
      chk("beq_taken", taken, 1);
      chk("beq_pcw", pc_write, 1);
      chk("beq_bop", branch_op, 0);
      step();
      chk("beq_bcnt", branch_cnt, 1);
      chk("beq_tcnt", taken_cnt, 1);

      // bgt, gt=0 -> not taken
      start = 1; branch_type = 2'b10;
      step();
      start = 0;
      step();
      step();
      chk("bgt_done", done, 1);
      chk("bgt_taken", taken, 0);
      chk("bgt_pcw", pc_write, 0);
      chk("bgt_bop", branch_op, 2);
      step();
      chk("bgt_bcnt", branch_cnt, 2);
      chk("bgt_tcnt", taken_cnt, 1);

      // start while busy is ignored
      start = 1; branch_type = 2'b00;
      step();
      branch_type = 2'b01;
      step();
      start = 0;
      step();
      chk("ign_bop", branch_op, 0);
      chk("ign_done", done, 1);
      step();
      chk("ign_busy", busy, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("ign_no_done", done, 0);
      end
      chk("ign_bcnt", branch_cnt, 3);

      // five taken branches: 2-bit counters saturate
      for (int i = 0; i < 5; i++) run_br(2'b00, 1'b1, 1'b0);
      chk("sat_tcnt16", taken_cnt, 6);
      chk("sat_bcnt16", branch_cnt, 8);
      chk("sat_tcnt2", taken_cnt2, 3);
      chk("sat_bcnt2", branch_cnt2, 3);

      // clear together with a resolve
      start = 1; branch_type = 2'b00;
      step();
      start = 0;
      step();
      alu_zero = 1;
      step();
      alu_zero = 0; clr_stats = 1;
      chk("clr_done", done, 1);
      step();
      clr_stats = 0;
      chk("clr_bcnt", branch_cnt, 0);
      chk("clr_tcnt", taken_cnt, 0);
      chk("clr_bcnt2", branch_cnt2, 0);
      chk("clr_tcnt2", taken_cnt2, 0);

      // back-to-back ble
      start = 1; branch_type = 2'b11;
      step();
      start = 0;
      step();
      alu_gt = 1;
      step();
      alu_gt = 0;
      chk("b2b_done1", done, 1);
      chk("b2b_taken1", taken, 0);
      t1 = cyc;
      step();
      start = 1; branch_type = 2'b11;
      step();
      start = 0;
      step();
      step();
      chk("b2b_done2", done, 1);
      chk("b2b_taken2", taken, 1);
      t2 = cyc;
      chk("b2b_gap", t2 - t1, 4);
      step();

      // reset during COMPARE
      start = 1; branch_type = 2'b00;
      step();
      start = 0;
      step();
      alu_zero = 1;
      reset_n = 0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_alu_op", alu_op, 0);
      chk("arst_src_a", alu_src_a, 0);
      chk("arst_bcnt", branch_cnt, 0);
      chk("arst_tcnt", taken_cnt, 0);
      alu_zero = 0;
      step();
      step();
      reset_n = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("arst_no_done", done, 0);
         chk("arst_no_pcw", pc_write, 0);
      end

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         start       = ($urandom_range(0, 2) == 0);
         branch_type = 2'($urandom_range(0, 3));
         alu_zero    = 1'($urandom_range(0, 1));
         alu_gt      = 1'($urandom_range(0, 1));
         clr_stats   = ($urandom_range(0, 60) == 0);
         reset_n     = ($urandom_range(0, 200) != 0);
         step();
      end
      reset_n = 1; start = 0; clr_stats = 0;
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
